// File: rtl/ps2_keys_pkg.sv
// Shared scan-code constants and state encoding for the PS/2 command decoder.
package ps2_keys_pkg;

  localparam logic [7:0] KEY_B      = 8'h32;
  localparam logic [7:0] KEY_L      = 8'h4B;
  localparam logic [7:0] KEY_M      = 8'h3A;
  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BPM_ENTRY  = 2'd1,
    LANE_ENTRY = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_digit_lut.sv
// Maps a set-2 make code onto its decimal digit value.
module ps2_digit_lut (
  input  logic [7:0] scan_code,
  output logic [3:0] digit,
  output logic       is_digit
);

  always_comb begin
    digit    = '0;
    is_digit = 1'b1;
    case (scan_code)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_command_decoder.sv
// Turns PS/2 make/break bytes into BPM/lane settings and command pulses
// for the step sequencer.
module ps2_command_decoder
  import ps2_keys_pkg::*;
#(
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned BPM_MIN     = 20,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned NUM_LANES   = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [9:0] bpm,
  output logic       bpm_update,
  output logic [2:0] lane_sel,
  output logic       lane_update,
  output logic       mute_toggle,
  output logic       play_toggle,
  output logic       entry_active,
  output logic [9:0] entry_value
);

  state_t     state;
  logic       break_pending;
  logic       ext_pending;
  logic [1:0] digit_count;
  logic [1:0] digit_limit;
  logic [3:0] digit;
  logic       is_digit;
  logic [9:0] entry_next;
  logic [9:0] bpm_clamped;

  ps2_digit_lut u_digit_lut (
    .scan_code (scan_code),
    .digit     (digit),
    .is_digit  (is_digit)
  );

  // Digit limits keep entry_value <= 999, so the 10-bit product cannot wrap.
  always_comb begin
    digit_limit = (state == BPM_ENTRY) ? 2'd3 : 2'd1;
    entry_next  = entry_value * 10'd10 + {6'b0, digit};
    if (entry_value < 10'(BPM_MIN))
      bpm_clamped = 10'(BPM_MIN);
    else if (entry_value > 10'(BPM_MAX))
      bpm_clamped = 10'(BPM_MAX);
    else
      bpm_clamped = entry_value;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      digit_count   <= '0;
      bpm           <= 10'(BPM_DEFAULT);
      bpm_update    <= 1'b0;
      lane_sel      <= '0;
      lane_update   <= 1'b0;
      mute_toggle   <= 1'b0;
      play_toggle   <= 1'b0;
      entry_active  <= 1'b0;
      entry_value   <= '0;
    end else begin
      bpm_update  <= 1'b0;
      lane_update <= 1'b0;
      mute_toggle <= 1'b0;
      play_toggle <= 1'b0;

      if (scan_valid) begin
        if (break_pending) begin
          // The released key's code is swallowed without any decoding.
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
        end else if (scan_code == BREAK_CODE) begin
          break_pending <= 1'b1;
        end else if (scan_code == EXT_CODE) begin
          ext_pending <= 1'b1;
        end else begin
          if (ext_pending)
            ext_pending <= 1'b0;

          if (scan_code == KEY_B) begin
            state        <= BPM_ENTRY;
            entry_active <= 1'b1;
            entry_value  <= '0;
            digit_count  <= '0;
          end else if (scan_code == KEY_L) begin
            state        <= LANE_ENTRY;
            entry_active <= 1'b1;
            entry_value  <= '0;
            digit_count  <= '0;
          end else if (scan_code == KEY_M) begin
            mute_toggle <= 1'b1;
          end else if (scan_code == KEY_SPACE) begin
            play_toggle <= 1'b1;
          end else if (state != IDLE) begin
            if (is_digit) begin
              if (digit_count < digit_limit) begin
                entry_value <= entry_next;
                digit_count <= digit_count + 2'd1;
              end
            end else if (scan_code == KEY_ENTER) begin
              if (digit_count != '0) begin
                if (state == BPM_ENTRY) begin
                  bpm        <= bpm_clamped;
                  bpm_update <= 1'b1;
                end else if (entry_value < 10'(NUM_LANES)) begin
                  lane_sel    <= entry_value[2:0];
                  lane_update <= 1'b1;
                end
              end
              state        <= IDLE;
              entry_active <= 1'b0;
            end else if (scan_code == KEY_ESC) begin
              state        <= IDLE;
              entry_active <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Directed bench for ps2_command_decoder with a queued pulse scoreboard.
module tb_ps2_command_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [9:0] bpm;
  logic       bpm_update;
  logic [2:0] lane_sel;
  logic       lane_update;
  logic       mute_toggle;
  logic       play_toggle;
  logic       entry_active;
  logic [9:0] entry_value;

  localparam logic [3:0] K_BPM  = 4'b0001;
  localparam logic [3:0] K_LANE = 4'b0010;
  localparam logic [3:0] K_MUTE = 4'b0100;
  localparam logic [3:0] K_PLAY = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    int         value;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  ps2_command_decoder #(
    .BPM_DEFAULT (120),
    .BPM_MIN     (20),
    .BPM_MAX     (300),
    .NUM_LANES   (8)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .bpm          (bpm),
    .bpm_update   (bpm_update),
    .lane_sel     (lane_sel),
    .lane_update  (lane_update),
    .mute_toggle  (mute_toggle),
    .play_toggle  (play_toggle),
    .entry_active (entry_active),
    .entry_value  (entry_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] code);
    @(posedge clk);
    #1;
    scan_code  = code;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic expect_pulse(input logic [3:0] kind, input int value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse seen must match the head of the scoreboard.
  initial begin
    logic [3:0] p;
    exp_t       e;
    forever begin
      @(negedge clk);
      p = {play_toggle, mute_toggle, lane_update, bpm_update};
      if (!reset && p != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'(p), 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", int'(p), int'(e.kind));
          if (e.kind == K_BPM)  chk("bpm_value", int'(bpm), e.value);
          if (e.kind == K_LANE) chk("lane_value", int'(lane_sel), e.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(5);
    chk("reset_bpm", int'(bpm), 120);
    chk("reset_lane", int'(lane_sel), 0);
    chk("reset_active", int'(entry_active), 0);
    chk("reset_entry", int'(entry_value), 0);

    // Lane select 1
    send(8'h4B);
    chk("lane_entry_active", int'(entry_active), 1);
    send(8'h16);
    chk("lane_entry_value", int'(entry_value), 1);
    expect_pulse(K_LANE, 1);
    send(8'h5A);
    chk("lane_after_active", int'(entry_active), 0);
    chk("lane_sel_1", int'(lane_sel), 1);

    // BPM 999 clamps to 300; fourth digit ignored
    send(8'h32);
    send(8'h46); send(8'h46); send(8'h46);
    chk("bpm_entry_999", int'(entry_value), 999);
    send(8'h46);
    chk("bpm_entry_4th_digit", int'(entry_value), 999);
    expect_pulse(K_BPM, 300);
    send(8'h5A);
    chk("bpm_clamp_hi", int'(bpm), 300);
    chk("entry_held", int'(entry_value), 999);

    // Released 9 ignored -> 95
    send(8'h32);
    send(8'h46); send(8'hF0); send(8'h46); send(8'h2E);
    chk("bpm_entry_95", int'(entry_value), 95);
    expect_pulse(K_BPM, 95);
    send(8'h5A);
    chk("bpm_95", int'(bpm), 95);

    // Lane 9 rejected; lane 7 accepted; lane 8 rejected
    send(8'h4B); send(8'h46); send(8'h5A);
    chk("lane_reject_9", int'(lane_sel), 1);
    send(8'h4B); send(8'h3D);
    expect_pulse(K_LANE, 7);
    send(8'h5A);
    chk("lane_sel_7", int'(lane_sel), 7);
    send(8'h4B); send(8'h3E); send(8'h5A);
    chk("lane_reject_8", int'(lane_sel), 7);

    // Esc aborts, low clamp, Enter with no digits
    send(8'h32); send(8'h16); send(8'h76);
    chk("esc_bpm", int'(bpm), 95);
    chk("esc_active", int'(entry_active), 0);
    send(8'h32); send(8'h2E);
    expect_pulse(K_BPM, 20);
    send(8'h5A);
    chk("bpm_clamp_lo", int'(bpm), 20);
    send(8'h32); send(8'h5A);
    chk("empty_enter_bpm", int'(bpm), 20);
    chk("empty_enter_active", int'(entry_active), 0);

    // Space, its release, extended Space, mute inside an entry
    expect_pulse(K_PLAY, 0);
    send(8'h29);
    send(8'hF0); send(8'h29);
    expect_pulse(K_PLAY, 0);
    send(8'hE0); send(8'h29);
    expect_pulse(K_MUTE, 0);
    send(8'h3A);
    send(8'h32); send(8'h26);
    expect_pulse(K_MUTE, 0);
    send(8'h3A);
    chk("mute_keeps_entry", int'(entry_active), 1);
    send(8'h36);
    chk("entry_after_mute", int'(entry_value), 36);

    // Reset mid-entry discards it
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    chk("rst_mid_bpm", int'(bpm), 120);
    chk("rst_mid_active", int'(entry_active), 0);
    chk("rst_mid_entry", int'(entry_value), 0);
    send(8'h2E); send(8'h5A);
    chk("idle_digit_ignored", int'(entry_value), 0);

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
